rho_pi_inv_seq: RTL and testbench
=================================

Name: rho_pi_inv_seq

Overview:
Sequential inverse of the Keccak rho+pi step: S_o = pi^-1(rho^-1(S)), lane 0 passes through unchanged. Sits beside the combinational rho_pi in the SHA-3 core. Used for state reconstruction and on-chip self-check: rho_pi followed by rho_pi_inv_seq must return the original state. Processes STEPS_PER_CYCLE lanes per clock with shared rotators to save area, and uses valid/ready handshakes on both sides.

Parameters:
STEPS_PER_CYCLE, 1, inverse lane steps per clock; legal values 1,2,3,4,6,8,12,24; any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input state valid
s_ready  output  1  block can accept a state
s_data  input  1600  input state, lane k = s_data[64k+63:64k]
m_valid  output  1  result valid
m_ready  input  1  downstream accepts result
m_data  output  1600  result state, same lane packing
busy  output  1  high in RUN or DONE

Behaviour:
- Constants: PILN p[0..23] = 10,7,11,17,18,3,5,16,8,21,24,4,15,23,19,13,12,2,20,14,22,9,6,1. ROTC r[0..23] = 1,3,6,10,15,21,28,36,45,55,2,14,27,41,56,8,25,43,62,18,39,61,20,44. Define p[-1] = 1.
- Step i (0..23): out[p[i-1]] = ROTR64(in[p[i]], r[i]). Lane 0: out[0] = in[0].
- Registers: in_reg (1600), out_reg (1600, drives m_data), cnt (5 bit), state. in_reg and out_reg are separate because in-place update conflicts on lane 1.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - s_ready = 1.
  - On s_valid && s_ready: in_reg <= s_data, out_reg[0] <= s_data lane 0, cnt <= 0, go to RUN.
- RUN:
  - s_ready = 0.
  - Each edge performs steps cnt .. cnt+STEPS_PER_CYCLE-1 and advances cnt by STEPS_PER_CYCLE.
  - When the last step (23) completes, go to DONE.
  - s_valid is ignored.
- DONE:
  - m_valid = 1; out_reg is stable and held.
  - On m_ready: go to IDLE, m_valid falls the next cycle.
  - No new accept in the same cycle as the m_ready handshake (s_ready = 0 in DONE).
- Latency: m_valid rises 24/STEPS_PER_CYCLE clocks after the accepting edge (24 for default). Throughput is one state per latency+2 clocks.
- Rotation: shift amounts are 6-bit values, r in 1..62, so there is no zero or 64 shift case. ROTR64(x,n) = (x>>n)|(x<<(64-n)).
- Backpressure: m_ready held low keeps the block in DONE indefinitely with outputs constant. m_ready high outside DONE has no effect.
- Reset (async, any state including mid-RUN): state = IDLE, cnt = 0, in_reg = 0, out_reg = 0, m_valid = 0, busy = 0. s_ready = 1 after reset deasserts. A partially computed state is discarded.
- s_data is sampled only at the accepting edge and may change afterwards.

Decomposition:
- Shared package sha3_pkg holds the PILN and ROTC tables, the lane width (64), the lane count (25), and a ROTR64 function. The forward rho_pi is updated to use the same tables.
- One sub-module, rho_pi_inv_lane: combinational single step, with inputs lane data and step index and outputs the rotated lane and destination index. It is instantiated STEPS_PER_CYCLE times.

Test Plan:
- Input lane 10 = 64'h2, other lanes 0 -> out lane 1 = 64'h1, other lanes 0; m_valid exactly 24 clocks after accept.
- Input lane 1 = 64'h1 -> out lane 6 = 64'h0000_0000_0010_0000 (ROTR 44).
- Input lane 0 = 64'hDEAD_BEEF_0123_4567, others random -> out lane 0 identical.
- Random 1600-bit X into rho_pi, result into this block -> m_data == X.
  - Repeat 1000 vectors for each STEPS_PER_CYCLE value in 1, 4, 24.
  - Check latency 24, 6 and 1 respectively.
- Hold m_ready = 0 for 10 clocks in DONE -> m_valid stays 1, m_data is constant, s_ready = 0; s_valid pulses are ignored.
- Assert rst_n low at RUN cnt = 12 -> outputs go to reset values immediately (async); next accepted state produces the correct result with no residue.

Source files
------------

// File: rtl/sha3_pkg.sv
// sha3_pkg: Keccak rho+pi lane tables, lane geometry, FSM type and the 64-bit rotate used by rho_pi and its inverse.
package sha3_pkg;
    localparam int LANE_W  = 64;
    localparam int N_LANES = 25;
    localparam int N_STEPS = 24;
    typedef logic [N_LANES-1:0][LANE_W-1:0] state_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    localparam logic [4:0] PILN [N_STEPS] = '{
        5'd10, 5'd7,  5'd11, 5'd17, 5'd18, 5'd3,  5'd5,  5'd16,
        5'd8,  5'd21, 5'd24, 5'd4,  5'd15, 5'd23, 5'd19, 5'd13,
        5'd12, 5'd2,  5'd20, 5'd14, 5'd22, 5'd9,  5'd6,  5'd1
    };
    localparam logic [5:0] ROTC [N_STEPS] = '{
        6'd1,  6'd3,  6'd6,  6'd10, 6'd15, 6'd21, 6'd28, 6'd36,
        6'd45, 6'd55, 6'd2,  6'd14, 6'd27, 6'd41, 6'd56, 6'd8,
        6'd25, 6'd43, 6'd62, 6'd18, 6'd39, 6'd61, 6'd20, 6'd44
    };
    // Amounts are always 1..62, so neither shift reaches the full lane width.
    function automatic logic [LANE_W-1:0] rotr64(input logic [LANE_W-1:0] x, input logic [5:0] n);
        return (x >> n) | (x << (7'd64 - {1'b0, n}));
    endfunction
    function automatic bit legal_spc(input int n);
        return n >= 1 && n <= N_STEPS && (N_STEPS % n) == 0;
    endfunction
endpackage

// File: rtl/rho_pi_inv_lane.sv
// rho_pi_inv_lane: one inverse rho+pi step -- rotates the source lane right and names its destination lane.
module rho_pi_inv_lane
    import sha3_pkg::*;
(
    input  logic [LANE_W-1:0] lane,
    input  logic [4:0]        step,
    output logic [LANE_W-1:0] rot,
    output logic [4:0]        dst
);
    assign rot = rotr64(lane, ROTC[step]);
    assign dst = (step == 5'd0) ? 5'd1 : PILN[step - 5'd1];
endmodule

// File: rtl/rho_pi_inv_seq.sv
// rho_pi_inv_seq: sequential inverse of Keccak rho+pi, STEPS_PER_CYCLE lane steps per clock,
// valid/ready on both sides.
module rho_pi_inv_seq
    import sha3_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [1599:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [1599:0] m_data,
    output logic          busy
);
    if (!legal_spc(STEPS_PER_CYCLE)) begin : g_bad_spc
        $error("rho_pi_inv_seq: STEPS_PER_CYCLE must be one of 1,2,3,4,6,8,12,24");
    end
    localparam logic [4:0] SPC = 5'(STEPS_PER_CYCLE);
    // Separate source and result registers: an in-place chain would clobber lane 1 before it is read.
    state_t            in_reg;
    state_t            out_reg;
    fsm_t              state;
    logic [4:0]        cnt;
    logic              last;
    logic [4:0]        step [STEPS_PER_CYCLE];
    logic [4:0]        dst  [STEPS_PER_CYCLE];
    logic [LANE_W-1:0] rot  [STEPS_PER_CYCLE];
    for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
        assign step[j] = cnt + 5'(j);
        rho_pi_inv_lane u_lane (
            .lane (in_reg[PILN[step[j]]]),
            .step (step[j]),
            .rot  (rot[j]),
            .dst  (dst[j])
        );
    end
    assign last   = (cnt + SPC) == 5'(N_STEPS);
    assign m_data = out_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            in_reg  <= '0;
            out_reg <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s_valid && s_ready) begin
                    in_reg     <= s_data;
                    out_reg[0] <= s_data[LANE_W-1:0];
                    cnt        <= '0;
                    state      <= RUN;
                    s_ready    <= 1'b0;
                    busy       <= 1'b1;
                end
                RUN: begin
                    for (int j = 0; j < STEPS_PER_CYCLE; j++) out_reg[dst[j]] <= rot[j];
                    cnt <= last ? 5'd0 : cnt + SPC;
                    if (last) begin
                        state   <= DONE;
                        m_valid <= 1'b1;
                    end
                end
                DONE: if (m_ready) begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rho_pi_inv_seq.sv
// tb_rho_pi_inv_seq: round-trips random states through a textbook (x,y) rho+pi model and this block,
// for STEPS_PER_CYCLE = 1, 4 and 24.
module tb_rho_pi_inv_seq;
    localparam int SPC [3] = '{1, 4, 24};
    // Keccak rho offsets indexed by lane x+5y.
    localparam int RHO [25] = '{
        0,  1, 62, 28, 27,
        36, 44, 6, 55, 20,
        3, 10, 43, 25, 39,
        41, 45, 15, 21, 8,
        18, 2, 61, 56, 14
    };
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sv [3];
    logic          sr [3];
    logic          mv [3];
    logic          mr [3];
    logic          bz [3];
    logic [1599:0] sd [3];
    logic [1599:0] md [3];
    int            n_checks = 0;
    int            n_fail = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        rho_pi_inv_seq #(.STEPS_PER_CYCLE(SPC[g])) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .s_valid (sv[g]),
            .s_ready (sr[g]),
            .s_data  (sd[g]),
            .m_valid (mv[g]),
            .m_ready (mr[g]),
            .m_data  (md[g]),
            .busy    (bz[g])
        );
    end
    task automatic check(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
        int l;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            l = 0;
            for (int i = 24; i >= 0; i--) if (got[64*i+:64] !== exp[64*i+:64]) l = i;
            $display("FAIL %s: lane %0d got %h expected %h", tag, l, got[64*l+:64], exp[64*l+:64]);
        end
    endtask
    function automatic logic [1599:0] rand_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[32*i+:32] = $urandom;
        return v;
    endfunction
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
    // rho then pi: B[y, 2x+3y] = ROTL(A[x,y], rho[x,y])
    function automatic logic [1599:0] fwd(input logic [1599:0] a);
        logic [1599:0] b;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[64*(y+5*((2*x+3*y)%5))+:64] = rotl(a[64*(x+5*y)+:64], RHO[x+5*y]);
        return b;
    endfunction
    function automatic logic [1599:0] inv(input logic [1599:0] b);
        logic [1599:0] a;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                a[64*(x+5*y)+:64] = rotr(b[64*(y+5*((2*x+3*y)%5))+:64], RHO[x+5*y]);
        return a;
    endfunction
    task automatic xact(input int k, input logic [1599:0] din, output logic [1599:0] dout, output int lat);
        @(negedge clk);
        check("s_ready idle", 1600'(sr[k]), 1600'(1));
        sv[k] = 1'b1;
        sd[k] = din;
        @(negedge clk);
        sv[k] = 1'b0;
        sd[k] = rand_state();
        lat = 0;
        while (!mv[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        dout = md[k];
        mr[k] = 1'b1;
        @(negedge clk);
        mr[k] = 1'b0;
        check("m_valid falls", 1600'(mv[k]), 1600'(0));
    endtask
    initial begin
        logic [1599:0] d, e, y, held;
        int lat;
        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0;
            mr[k] = 1'b0;
            sd[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst s_ready", 1600'(sr[k]), 1600'(1));
            check("rst m_valid", 1600'(mv[k]), 1600'(0));
            check("rst busy", 1600'(bz[k]), 1600'(0));
            check("rst m_data", md[k], '0);
        end
        rst_n = 1'b1;
        d = '0;
        d[64*10+:64] = 64'h2;
        e = '0;
        e[64*1+:64] = 64'h1;
        xact(0, d, y, lat);
        check("lane10 to lane1", y, e);
        check("latency 24", 1600'(lat), 1600'(24));
        d = '0;
        d[64*1+:64] = 64'h1;
        e = '0;
        e[64*6+:64] = 64'h0000_0000_0010_0000;
        xact(0, d, y, lat);
        check("lane1 to lane6", y, e);
        d = rand_state();
        d[63:0] = 64'hDEAD_BEEF_0123_4567;
        xact(0, d, y, lat);
        check("lane0 passthru", 1600'(y[63:0]), 1600'(64'hDEAD_BEEF_0123_4567));
        check("inverse model", y, inv(d));
        d = rand_state();
        @(negedge clk);
        sv[1] = 1'b1;
        sd[1] = fwd(d);
        @(negedge clk);
        sv[1] = 1'b0;
        lat = 0;
        while (!mv[1] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 1600'(lat), 1600'(6));
        held = md[1];
        check("bp result", held, d);
        repeat (10) begin
            sv[1] = 1'($urandom_range(0, 1));
            sd[1] = rand_state();
            mr[1] = 1'b0;
            @(negedge clk);
            check("bp m_valid", 1600'(mv[1]), 1600'(1));
            check("bp m_data", md[1], held);
            check("bp s_ready", 1600'(sr[1]), 1600'(0));
        end
        sv[1] = 1'b0;
        mr[1] = 1'b1;
        @(negedge clk);
        mr[1] = 1'b0;
        check("bp release", 1600'(mv[1]), 1600'(0));
        sv[0] = 1'b1;
        sd[0] = fwd(rand_state());
        @(negedge clk);
        sv[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("mid-run busy", 1600'(bz[0]), 1600'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async m_valid", 1600'(mv[0]), 1600'(0));
        check("async busy", 1600'(bz[0]), 1600'(0));
        check("async s_ready", 1600'(sr[0]), 1600'(1));
        check("async m_data", md[0], '0);
        @(negedge clk);
        rst_n = 1'b1;
        d = rand_state();
        xact(0, fwd(d), y, lat);
        check("after reset", y, d);
        check("after reset lat", 1600'(lat), 1600'(24));
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < 1000; n++) begin
                d = rand_state();
                xact(k, fwd(d), y, lat);
                check("roundtrip", y, d);
                check("latency", 1600'(lat), 1600'(24 / SPC[k]));
            end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
